// File: rtl/bcd_decode_scheduler_if.sv
// Handshake bundle between the BCD decode scheduler, its requesters, the shared
// two-digit decoder and the character renderer.
interface bcd_decode_scheduler_if #(
    parameter int NUM_FIELDS = 3
);
    logic [NUM_FIELDS-1:0]   req;
    logic [6*NUM_FIELDS-1:0] field_values;
    logic [5:0]              dec_number;
    logic [3:0]              dec_decimals;
    logic [3:0]              dec_units;
    logic [8*NUM_FIELDS-1:0] digits_out;
    logic [NUM_FIELDS-1:0]   ack;
    logic [NUM_FIELDS-1:0]   err;
    logic                    busy;

    modport master (
        output req, field_values, dec_decimals, dec_units,
        input  dec_number, digits_out, ack, err, busy
    );

    modport slave (
        input  req, field_values, dec_decimals, dec_units,
        output dec_number, digits_out, ack, err, busy
    );
endinterface

// File: rtl/bcd_decode_scheduler.sv
// Round-robin scheduler sharing one registered binary-to-BCD decoder between
// NUM_FIELDS display fields. Define INIT_SCAN_EN to decode every field once after reset.
module bcd_decode_scheduler #(
    parameter int NUM_FIELDS = 3,
    parameter int DEC_LAT    = 1
) (
    input logic                   clk,
    input logic                   reset,
    bcd_decode_scheduler_if.slave bus
);
    localparam int GW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int CW = 3;

    typedef logic [GW-1:0] idx_t;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_t;

    state_t                  state_q, state_d;
    logic [NUM_FIELDS-1:0]   pending_q, pending_d;
    idx_t                    last_grant_q, last_grant_d;
    idx_t                    grant_q, grant_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [5:0]              dec_number_q, dec_number_d;
    logic [8*NUM_FIELDS-1:0] digits_q, digits_d;
    logic [NUM_FIELDS-1:0]   ack_q, ack_d;
    logic [NUM_FIELDS-1:0]   err_q, err_d;
    logic [NUM_FIELDS-1:0]   clr;
    logic                    found;
    idx_t                    pick;

    // First pending field at or after last_grant+1, wrapping.
    always_comb begin
        int unsigned idx;
        idx_t        cand;
        found = 1'b0;
        pick  = last_grant_q;
        for (int unsigned k = 1; k <= NUM_FIELDS; k++) begin
            idx = 32'(last_grant_q) + k;
            if (idx >= NUM_FIELDS)
                idx = idx - NUM_FIELDS;
            cand = idx_t'(idx);
            if (!found && pending_q[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        dec_number_d = dec_number_q;
        digits_d     = digits_q;
        ack_d        = '0;
        err_d        = err_q;
        clr          = '0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    cnt_d        = CW'(DEC_LAT);
                    state_d      = S_WAIT;
                    for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
                        if (idx_t'(i) == pick) begin
                            dec_number_d = bus.field_values[6*i +: 6];
                            clr[i]       = 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
                for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
                    if (idx_t'(i) == grant_q) begin
                        digits_d[8*i +: 8] = {bus.dec_decimals, bus.dec_units};
                        ack_d[i]           = 1'b1;
                        err_d[i]           = (bus.dec_decimals == 4'hF) || (bus.dec_units == 4'hF);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A request landing in the grant cycle survives the clear.
        pending_d = (pending_q & ~clr) | bus.req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
`ifdef INIT_SCAN_EN
            pending_q    <= '1;
`else
            pending_q    <= '0;
`endif
            last_grant_q <= idx_t'(NUM_FIELDS - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            dec_number_q <= '0;
            digits_q     <= '0;
            ack_q        <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            dec_number_q <= dec_number_d;
            digits_q     <= digits_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    assign bus.dec_number = dec_number_q;
    assign bus.digits_out = digits_q;
    assign bus.ack        = ack_q;
    assign bus.err        = err_q;
    assign bus.busy       = (state_q != S_IDLE) || (|pending_q);

endmodule

// File: tb/tb_bcd_decode_scheduler.sv
// Directed bench for bcd_decode_scheduler (NUM_FIELDS=3, DEC_LAT=1) with a
// one-cycle registered decoder model; table of single-field decodes plus corner sequences.
module tb_bcd_decode_scheduler;
    localparam int NF = 3;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    bcd_decode_scheduler_if #(.NUM_FIELDS(NF)) bus ();

    bcd_decode_scheduler #(.NUM_FIELDS(NF), .DEC_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared decoder: one registered stage, 4'hF digits for values above 59.
    always @(posedge clk) begin
        if (bus.dec_number < 6'd60) begin
            bus.dec_decimals <= 4'(bus.dec_number / 6'd10);
            bus.dec_units    <= 4'(bus.dec_number % 6'd10);
        end else begin
            bus.dec_decimals <= 4'hF;
            bus.dec_units    <= 4'hF;
        end
    end

    typedef struct {
        int unsigned fld;
        logic [5:0]  val;
        logic [7:0]  exp_digits;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [7];
    logic [23:0] exp_all;
    logic [2:0]  exp_err_all;
    logic [2:0]  exp_ack;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && bus.busy; i++)
            step();
        check("drain_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0] = '{fld: 1, val: 6'd37, exp_digits: 8'h37, exp_err: 1'b0};
        vecs[1] = '{fld: 0, val: 6'd60, exp_digits: 8'hFF, exp_err: 1'b1};
        vecs[2] = '{fld: 0, val: 6'd59, exp_digits: 8'h59, exp_err: 1'b0};
        vecs[3] = '{fld: 2, val: 6'd63, exp_digits: 8'hFF, exp_err: 1'b1};
        vecs[4] = '{fld: 2, val: 6'd0,  exp_digits: 8'h00, exp_err: 1'b0};
        vecs[5] = '{fld: 1, val: 6'd9,  exp_digits: 8'h09, exp_err: 1'b0};
        vecs[6] = '{fld: 0, val: 6'd10, exp_digits: 8'h10, exp_err: 1'b0};

        reset            = 1'b0;
        bus.req          = '0;
        bus.field_values = '0;
        do_reset();

        // Reset values
        check("rst_dec_number", 32'(bus.dec_number), 32'd0);
        check("rst_digits", 32'(bus.digits_out), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
`ifdef INIT_SCAN_EN
        check("rst_busy", 32'(bus.busy), 32'd1);
`else
        check("rst_busy", 32'(bus.busy), 32'd0);
`endif
        drain();

        // Single-field decodes: req at cycle 0, ack at cycle 4
        exp_all     = '0;
        exp_err_all = '0;
        for (int v = 0; v < 7; v++) begin
            bus.field_values[6*vecs[v].fld +: 6] = vecs[v].val;
            bus.req = 3'(1 << vecs[v].fld);
            step();
            bus.req = '0;
            check("vec_ack_c1", 32'(bus.ack), 32'd0);
            step();
            check("vec_decnum_c2", 32'(bus.dec_number), 32'(vecs[v].val));
            check("vec_ack_c2", 32'(bus.ack), 32'd0);
            step();
            check("vec_decnum_c3", 32'(bus.dec_number), 32'(vecs[v].val));
            check("vec_ack_c3", 32'(bus.ack), 32'd0);
            step();
            exp_all[8*vecs[v].fld +: 8] = vecs[v].exp_digits;
            exp_err_all[vecs[v].fld]    = vecs[v].exp_err;
            check("vec_ack_c4", 32'(bus.ack), 32'(1 << vecs[v].fld));
            check("vec_digits", 32'(bus.digits_out), 32'(exp_all));
            check("vec_err", 32'(bus.err), 32'(exp_err_all));
            step();
            check("vec_ack_c5", 32'(bus.ack), 32'd0);
            check("vec_busy_c5", 32'(bus.busy), 32'd0);
        end

        // All three requested in one cycle: grants 0,1,2
        do_reset();
        drain();
        bus.field_values = {6'd56, 6'd34, 6'd12};
        bus.req = 3'b111;
        for (int c = 1; c <= 12; c++) begin
            step();
            bus.req = '0;
            exp_ack = (c == 4) ? 3'b001 : (c == 7) ? 3'b010 : (c == 10) ? 3'b100 : 3'b000;
            check("all_ack", 32'(bus.ack), 32'(exp_ack));
            check("all_busy", 32'(bus.busy), (c < 10) ? 32'd1 : 32'd0);
        end
        check("all_digits", 32'(bus.digits_out), 32'h563412);

        // Re-request during WAIT: decoded twice, second time with new value
        do_reset();
        drain();
        bus.field_values = '0;
        bus.field_values[5:0] = 6'd10;
        bus.req = 3'b001;
        step();
        bus.req = '0;
        step();
        bus.field_values[5:0] = 6'd11;
        bus.req = 3'b001;
        step();
        bus.req = '0;
        check("rearm_ack_c3", 32'(bus.ack), 32'd0);
        step();
        check("rearm_ack_c4", 32'(bus.ack), 32'd1);
        check("rearm_dig_c4", 32'(bus.digits_out[7:0]), 32'h10);
        step();
        check("rearm_decnum_c5", 32'(bus.dec_number), 32'd11);
        check("rearm_ack_c5", 32'(bus.ack), 32'd0);
        step();
        check("rearm_ack_c6", 32'(bus.ack), 32'd0);
        step();
        check("rearm_ack_c7", 32'(bus.ack), 32'd1);
        check("rearm_dig_c7", 32'(bus.digits_out[7:0]), 32'h11);

        // Fields 0 and 2 held: alternate grants, field 1 starved of nothing
        do_reset();
        drain();
        bus.field_values = {6'd44, 6'd22, 6'd5};
        bus.req = 3'b101;
        for (int c = 1; c <= 13; c++) begin
            step();
            exp_ack = (c == 4 || c == 10) ? 3'b001 : (c == 7 || c == 13) ? 3'b100 : 3'b000;
            check("held_ack", 32'(bus.ack), 32'(exp_ack));
        end
        bus.req = '0;
        drain();
        check("held_f1_untouched", 32'(bus.digits_out[15:8]), 32'h00);
        check("held_digits_f0_f2", 32'({bus.digits_out[23:16], bus.digits_out[7:0]}), 32'h4405);

        // Reset during WAIT discards the decode
        bus.field_values = '0;
        bus.field_values[11:6] = 6'd37;
        bus.req = 3'b010;
        step();
        bus.req = '0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstw_dec_number", 32'(bus.dec_number), 32'd0);
        check("rstw_digits", 32'(bus.digits_out), 32'd0);
        check("rstw_err", 32'(bus.err), 32'd0);
        check("rstw_ack", 32'(bus.ack), 32'd0);
        for (int c = 1; c <= 10; c++) begin
            step();
`ifdef INIT_SCAN_EN
            exp_ack = (c == 3) ? 3'b001 : (c == 6) ? 3'b010 : (c == 9) ? 3'b100 : 3'b000;
`else
            exp_ack = 3'b000;
`endif
            check("rstw_ack_after", 32'(bus.ack), 32'(exp_ack));
        end
`ifndef INIT_SCAN_EN
        check("rstw_busy", 32'(bus.busy), 32'd0);
        check("rstw_digits_after", 32'(bus.digits_out), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
